// File: rtl/vga_scanout_pkg.sv
// Shared VGA definitions: frame geometry, 640x480@60 timing and swap FSM encoding.
package vga_scanout_pkg;
    localparam int WIDTH       = 8;
    localparam int HEIGHT      = 6;
    localparam int PIXEL_SIZE  = 3;
    localparam int PACKED_SIZE = WIDTH * HEIGHT * PIXEL_SIZE;
    localparam int SCALE       = 80;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        SWAP_IDLE = 2'd0,
        SWAP_REQ  = 2'd1,
        SWAP_DONE = 2'd2
    } swap_state_t;
endpackage

// File: rtl/vga_scanout_if.sv
// Display-side bundle: registered raster outputs plus the buffer swap handshake.
interface vga_scanout_if #(
    parameter int PIXEL_SIZE = vga_scanout_pkg::PIXEL_SIZE
);
    logic                  hsync;
    logic                  vsync;
    logic                  video_on;
    logic [PIXEL_SIZE-1:0] pixel_out;
    logic                  frame_start;
    logic                  swap_req;
    logic                  swap_ack;
    logic                  swap_missed;

    modport master (
        output hsync, vsync, video_on, pixel_out, frame_start, swap_req, swap_missed,
        input  swap_ack
    );
    modport slave (
        input  hsync, vsync, video_on, pixel_out, frame_start, swap_req, swap_missed,
        output swap_ack
    );
endinterface

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with combinational sync and active-area decode.
module vga_timing #(
    parameter int H_ACTIVE = vga_scanout_pkg::H_ACTIVE,
    parameter int H_FP     = vga_scanout_pkg::H_FP,
    parameter int H_SYNC   = vga_scanout_pkg::H_SYNC,
    parameter int H_BP     = vga_scanout_pkg::H_BP,
    parameter int V_ACTIVE = vga_scanout_pkg::V_ACTIVE,
    parameter int V_FP     = vga_scanout_pkg::V_FP,
    parameter int V_SYNC   = vga_scanout_pkg::V_SYNC,
    parameter int V_BP     = vga_scanout_pkg::V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          line_end,
    output logic          frame_end,
    output logic          hsync,
    output logic          vsync,
    output logic          active
);
    import vga_scanout_pkg::*;

    assign line_end  = (h_cnt == HW'(H_TOTAL - 1));
    assign frame_end = line_end && (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Sync pulses are active-low inside the sync window between porches.
    assign hsync  = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync  = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
endmodule

// File: rtl/vga_scanout.sv
// Scans a packed frame out as scaled VGA video; runs the tear-free buffer swap handshake in vblank.
module vga_scanout #(
    parameter int WIDTH      = vga_scanout_pkg::WIDTH,
    parameter int HEIGHT     = vga_scanout_pkg::HEIGHT,
    parameter int PIXEL_SIZE = vga_scanout_pkg::PIXEL_SIZE,
    parameter int SCALE      = vga_scanout_pkg::SCALE,
    parameter int H_ACTIVE   = vga_scanout_pkg::H_ACTIVE,
    parameter int H_FP       = vga_scanout_pkg::H_FP,
    parameter int H_SYNC     = vga_scanout_pkg::H_SYNC,
    parameter int H_BP       = vga_scanout_pkg::H_BP,
    parameter int V_ACTIVE   = vga_scanout_pkg::V_ACTIVE,
    parameter int V_FP       = vga_scanout_pkg::V_FP,
    parameter int V_SYNC     = vga_scanout_pkg::V_SYNC,
    parameter int V_BP       = vga_scanout_pkg::V_BP
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [WIDTH*HEIGHT*PIXEL_SIZE-1:0]  packed_buffer,
    vga_scanout_if.master                       bus
);
    import vga_scanout_pkg::*;

    localparam int PACKED = WIDTH * HEIGHT * PIXEL_SIZE;
    localparam int IW     = $clog2(PACKED);
    localparam int SW     = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int RW     = $clog2(HEIGHT + 1);
    localparam int HW     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          line_end, frame_end, hsync_c, vsync_c, active;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .reset(reset), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .line_end(line_end), .frame_end(frame_end),
        .hsync(hsync_c), .vsync(vsync_c), .active(active)
    );

    // Sub-pixel counters replace a divide; col/row saturate at WIDTH/HEIGHT past the image edge.
    logic [SW-1:0] sx, sy;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_ff @(posedge clk) begin
        if (reset) begin
            sx  <= '0;
            sy  <= '0;
            col <= '0;
            row <= '0;
        end else begin
            if (line_end) begin
                sx  <= '0;
                col <= '0;
            end else if (sx == SW'(SCALE - 1)) begin
                sx <= '0;
                if (col != CW'(WIDTH)) col <= col + 1'b1;
            end else begin
                sx <= sx + 1'b1;
            end

            if (frame_end) begin
                sy  <= '0;
                row <= '0;
            end else if (line_end) begin
                if (sy == SW'(SCALE - 1)) begin
                    sy <= '0;
                    if (row != RW'(HEIGHT)) row <= row + 1'b1;
                end else begin
                    sy <= sy + 1'b1;
                end
            end
        end
    end

    logic                  in_img;
    logic [IW-1:0]         bit_idx;
    logic [PIXEL_SIZE-1:0] pix;

    always_comb begin
        in_img  = active && (col < CW'(WIDTH)) && (row < RW'(HEIGHT));
        bit_idx = '0;
        if (in_img) bit_idx = IW'((IW'(row) * IW'(WIDTH) + IW'(col)) * IW'(PIXEL_SIZE));
        pix = in_img ? packed_buffer[bit_idx +: PIXEL_SIZE] : '0;
    end

    swap_state_t state, state_next;
    logic        missed_next;

    always_ff @(posedge clk) begin
        if (reset) state <= SWAP_IDLE;
        else       state <= state_next;
    end

    // An ack landing on the end-of-frame cycle still counts as a completed swap.
    always_comb begin
        state_next  = state;
        missed_next = 1'b0;
        unique case (state)
            SWAP_IDLE: if (h_cnt == '0 && v_cnt == VW'(V_ACTIVE)) state_next = SWAP_REQ;
            SWAP_REQ: begin
                if (frame_end) begin
                    state_next  = SWAP_IDLE;
                    missed_next = !bus.swap_ack;
                end else if (bus.swap_ack) begin
                    state_next = SWAP_DONE;
                end
            end
            SWAP_DONE: if (frame_end) state_next = SWAP_IDLE;
            default:   state_next = SWAP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.video_on    <= 1'b0;
            bus.pixel_out   <= '0;
            bus.frame_start <= 1'b0;
            bus.swap_req    <= 1'b0;
            bus.swap_missed <= 1'b0;
        end else begin
            bus.hsync       <= hsync_c;
            bus.vsync       <= vsync_c;
            bus.video_on    <= active;
            bus.pixel_out   <= pix;
            bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
            bus.swap_req    <= (state_next == SWAP_REQ);
            bus.swap_missed <= missed_next;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster; expected outputs derived from raster position arithmetic.
module tb_vga_scanout;
    localparam int W = 4, H = 3, PS = 3, SC = 3;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int PK = W * H * PS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PK-1:0] packed_buffer = '0;

    vga_scanout_if #(.PIXEL_SIZE(PS)) bus();

    vga_scanout #(
        .WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(PS), .SCALE(SC),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .packed_buffer(packed_buffer), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          video_on;
        logic [PS-1:0] pixel;
        logic          frame_start;
        logic          swap_req;
        logic          swap_missed;
    } exp_t;

    exp_t sb[$];
    int   cnt = 0;
    bit   acked = 1'b0;
    int   vectors = 0, miscompares = 0;
    int   fs_seen = 0, fs_expected = 0;

    // Reference: each edge registers the outputs for raster position cnt (or reset values).
    initial forever begin
        exp_t e;
        int p, h, v, c, r;
        @(posedge clk);
        e = '0;
        if (reset) begin
            e.hsync = 1'b1;
            e.vsync = 1'b1;
            cnt = 0;
            acked = 1'b0;
        end else begin
            p = cnt % FRAME;
            h = p % HT;
            v = p / HT;
            if (p == 0) acked = 1'b0;
            e.hsync    = !(h >= HA + HFP && h < HA + HFP + HS);
            e.vsync    = !(v >= VA + VFP && v < VA + VFP + VS);
            e.video_on = (h < HA) && (v < VA);
            c = h / SC;
            r = v / SC;
            if (e.video_on && c < W && r < H) e.pixel = packed_buffer[(r * W + c) * PS +: PS];
            e.frame_start = (p == 0);
            if (p > VA * HT && bus.swap_ack) acked = 1'b1;
            e.swap_req    = (p >= VA * HT) && (p < FRAME - 1) && !acked;
            e.swap_missed = (p == FRAME - 1) && !acked;
            if (e.frame_start) fs_expected++;
            cnt++;
        end
        sb.push_back(e);
    end

    initial forever begin
        exp_t e, a;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {bus.hsync, bus.vsync, bus.video_on, bus.pixel_out,
                 bus.frame_start, bus.swap_req, bus.swap_missed};
            vectors++;
            if (a.frame_start) fs_seen++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL raster pos=%0d t=%0t got{hs,vs,von,pix,fs,req,miss}=%b required=%b",
                         cnt - 1, $time, a, e);
            end
        end
    end

    // mode 0: no ack, 1: ack a few cycles into vblank, 2: random acks,
    // 3: random acks with the frame changing every cycle, 4: ack only on the last cycle of the frame
    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            case (mode)
                1: bus.swap_ack = ((cnt % FRAME) == VA * HT + 4);
                2: bus.swap_ack = ($urandom_range(7) == 0);
                3: begin
                    bus.swap_ack  = ($urandom_range(7) == 0);
                    packed_buffer = PK'({$urandom(), $urandom()});
                end
                4: bus.swap_ack = ((cnt % FRAME) == FRAME - 1);
                default: bus.swap_ack = 1'b0;
            endcase
        end
    endtask

    initial begin
        int guard;
        bus.swap_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        packed_buffer = '0;
        packed_buffer[0 +: PS] = 3'b101;
        packed_buffer[((H - 1) * W + (W - 1)) * PS +: PS] = 3'b010;
        run(FRAME + 10, 0);
        run(FRAME, 1);
        run(FRAME, 4);
        run(FRAME, 2);
        packed_buffer = PK'({$urandom(), $urandom()});
        run(FRAME, 2);
        run(FRAME, 3);

        guard = 0;
        while ((cnt % FRAME) != 7 * HT + 10 && guard < 2 * FRAME) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2 * FRAME) begin
            vectors++;
            miscompares++;
            $display("FAIL reset_target timeout after %0d cycles, required < %0d", guard, 2 * FRAME);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(FRAME + 20, 1);

        bus.swap_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        vectors++;
        if (fs_seen != fs_expected) begin
            miscompares++;
            $display("FAIL frame_start_count got=%0d required=%0d", fs_seen, fs_expected);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read-side counterpart of the double-buffered frame store: consumes the flat packed pixel bus and produces VGA raster timing (hsync, vsync, blanking) plus the pixel value for each screen position.
- Each logical pixel is scaled up to SCALE x SCALE screen pixels.
- Runs a swap handshake so the buffer writer toggles its select only during vertical blanking, which prevents tearing.

Parameters:
- WIDTH, 8, logical pixels per row
- HEIGHT, 6, logical rows
- PIXEL_SIZE, 3, bits per pixel (RGB 1:1:1)
- SCALE, 80, screen pixels per logical pixel in each axis; WIDTH*SCALE <= H_ACTIVE and HEIGHT*SCALE <= V_ACTIVE
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in clocks
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- packed_buffer  in  WIDTH*HEIGHT*PIXEL_SIZE  frame; pixel (row i, col j) at bits [(i*WIDTH+j)*PIXEL_SIZE +: PIXEL_SIZE]
- swap_ack  in  1  writer has toggled buf_sel
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high while the current pixel is in the active area
- pixel_out  out  PIXEL_SIZE  pixel colour; zero when not video_on or outside the scaled image
- frame_start  out  1  one-cycle pulse aligned with the first active pixel (0,0)
- swap_req  out  1  request to swap buffers
- swap_missed  out  1  one-cycle pulse: vblank ended without an ack

Behaviour:
- Counters:
  - h_cnt: 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); wraps to 0.
  - v_cnt: increments when h_cnt wraps; range 0..V_TOTAL-1 (525); wraps to 0.
- Scaling: the sub-pixel counters sx and sy (0..SCALE-1) and the logical indices col and row advance alongside h_cnt/v_cnt. No divider is allowed.
  - col resets at h_cnt==0.
  - row resets at v_cnt==0.
- Output stage: all outputs are registered, with one cycle of latency from the counter state. hsync, vsync, video_on and pixel_out are mutually aligned.
- hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751). vsync uses the same rule on v_cnt (490..491).
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- pixel_out = packed_buffer slice for (row, col) when video_on && col < WIDTH && row < HEIGHT; otherwise 0. packed_buffer is sampled in the cycle the counter addresses it.
- frame_start is high for the output cycle of h_cnt==0, v_cnt==0.
- Swap FSM states: IDLE, REQ, DONE.
  - IDLE -> REQ at h_cnt==0, v_cnt==V_ACTIVE (first blank line); swap_req goes high.
  - REQ -> DONE on swap_ack==1; swap_req drops the next cycle.
  - REQ -> IDLE at h_cnt==H_TOTAL-1, v_cnt==V_TOTAL-1: swap_req drops and swap_missed pulses one cycle.
  - DONE -> IDLE at that same end-of-frame point.
  - swap_ack is ignored in IDLE and DONE.
  - Ack on the same cycle as the end-of-frame point: counts as acked, so no swap_missed.
- Reset (synchronous, dominates everything):
  - h_cnt, v_cnt, sx, sy, col and row go to 0; FSM goes to IDLE.
  - Output values: hsync=1, vsync=1, video_on=0, pixel_out=0, frame_start=0, swap_req=0, swap_missed=0.
  - Reset mid-frame restarts the raster at (0,0). The first cycle after release is h_cnt=0; frame_start appears on the output the following cycle.
- Arithmetic: counter widths are $clog2 of their totals. Slice index arithmetic is sized to clog2 of the packed width, so no truncation is allowed.

Decomposition:
- Shared package/defines (extend the existing VGA defs):
  - WIDTH, HEIGHT, PIXEL_SIZE, PACKED_SIZE
  - timing constants and derived H_TOTAL/V_TOTAL
  - swap FSM state encoding
- One sub-module, vga_timing: the h/v counters plus sync/active generation, reusable by other display blocks.
- vga_scanout instantiates vga_timing and adds the scaling, pixel select and swap FSM.

Test Plan:
- Reset, release, run 420000 clocks. Required: hsync low exactly 96 clocks per 800, at output cycles 657..752 after release; vsync low for lines 490..491; frame_start pulses exactly once per 420000 clocks.
- packed_buffer with pixel (0,0)=3'b101 and (5,7)=3'b010, all others 0:
  - pixel_out=5 for screen x,y 0..79.
  - pixel_out=2 for x 560..639, y 400..479.
  - pixel_out=0 during blanking.
- Set SCALE=60 (image 480x360). Required: pixel_out=0 for x>=480 or y>=360 while video_on=1.
- swap_ack asserted 3 cycles after swap_req rises. Required:
  - swap_req rises at the first output of line 480 and falls 1 cycle after the ack;
  - no swap_missed;
  - no new req until the next frame.
- swap_ack never asserted. Required: swap_req holds through line 524; swap_missed pulses once at frame end; swap_req=0 on line 0. Stray acks in IDLE leave the FSM unchanged.
- Assert reset for 1 cycle at h=300, v=200. Required: outputs take their reset values, and the raster restarts with frame_start on the second cycle after release.
